tl_probe_responder: RTL and testbench
=====================================

TL_PROBE_RESPONDER -- requirements
Module: tl_probe_responder

Interface
REQ-001 SHALL have parameter AddrWidth, default 56, physical address width.
REQ-002 SHALL have parameter DataWidth, default 64, C-channel data width in bits; byte lanes BL = DataWidth/8.
REQ-003 SHALL have parameter SourceWidth, default 1, width of the B/C source field.
REQ-004 SHALL have ports clk_i (in, 1, sole clock) and rst_i (in, 1, reset); reset is asynchronous and active-high.
REQ-005 SHALL have B-channel inputs b_valid_i (1), b_opcode_i (3), b_param_i (3, toT/toB/toN cap), b_size_i (3, log2 bytes), b_source_i (SourceWidth), b_address_i (AddrWidth), and output b_ready_o (1).
REQ-006 SHALL have lookup port lkp_req_o (out, 1), lkp_addr_o (out, AddrWidth), lkp_hit_i (in, 1), lkp_perm_i (in, 2; 0=N, 1=B, 2=T), lkp_dirty_i (in, 1).
REQ-007 SHALL have data read port rd_req_o (out, 1), rd_addr_o (out, AddrWidth), rd_data_i (in, DataWidth).
REQ-008 SHALL have update port upd_valid_o (out, 1), upd_addr_o (out, AddrWidth), upd_perm_o (out, 2), upd_clean_o (out, 1).
REQ-009 SHALL have C-channel outputs c_valid_o (1), c_opcode_o (3), c_param_o (3), c_size_o (3), c_source_o (SourceWidth), c_address_o (AddrWidth), c_data_o (DataWidth), and input c_ready_i (1).

Function
REQ-010 SHALL implement states IDLE, LOOKUP, DECIDE, READ, CAPTURE, SEND; one probe in flight at a time.
REQ-011 SHALL drive b_ready_o=1 only in IDLE; B handshake (b_valid_i & b_ready_o) latches all B fields and moves to LOOKUP.
REQ-012 SHALL in LOOKUP assert lkp_req_o=1 for exactly one cycle with lkp_addr_o = latched address, then move to DECIDE.
REQ-013 SHALL in DECIDE sample lkp_hit_i/lkp_perm_i/lkp_dirty_i; miss forces cur=N, dirty=0.
REQ-014 SHALL compute c_param_o: cur T: cap toT->TtoT, toB->TtoB, toN->TtoN; cur B: cap toT or toB->BtoB, toN->BtoN; cur N->NtoN; cap values 3..7 treated as toN.
REQ-015 SHALL send ProbeAckData only when opcode==ProbeBlock, cur==T and dirty==1; otherwise ProbeAck; any opcode other than ProbeBlock is treated as ProbePerm.
REQ-016 SHALL from DECIDE go to SEND (ProbeAck) or READ (ProbeAckData) with beat counter cleared.
REQ-017 SHALL compute beats = max(1, 2^size / BL); counter width covers 16 beats at size 7.
REQ-018 SHALL in READ assert rd_req_o=1 one cycle with rd_addr_o = (address with low size bits cleared) + beat*BL, then CAPTURE; CAPTURE registers rd_data_i, then SEND.
REQ-019 SHALL in SEND hold c_valid_o=1 and all C fields stable until c_ready_i; c_size_o=latched size, c_source_o/c_address_o=latched values, c_data_o=captured data (0 for ProbeAck).
REQ-020 SHALL on SEND handshake: if last beat -> IDLE, else increment beat -> READ.
REQ-021 SHALL pulse upd_valid_o=1 for one cycle coincident with final C handshake, upd_addr_o=latched address, upd_perm_o = T for TtoT, B for TtoB/BtoB, N for TtoN/BtoN/NtoN, upd_clean_o=1 iff ProbeAckData sent.
REQ-022 SHALL give latency: B handshake cycle T -> c_valid_o at T+3 (ProbeAck) or T+5 (first data beat); 3 cycles per further data beat with c_ready_i held high.
REQ-023 SHALL not accept a new probe in the cycle of the final C handshake (b_ready_o rises next cycle).

Reset
REQ-024 SHALL on rst_i asynchronously force IDLE, clear beat counter and captured data, and drive all outputs 0 except b_ready_o, which is 1 once rst_i deasserts.
REQ-025 SHALL, when reset asserts mid-probe, abandon it with no upd_valid_o pulse and no further C beats.

Verification
REQ-026 SHALL cover ProbePerm toN, hit perm=T dirty=1 -> single ProbeAck, param TtoN(1), c_valid at T+3, upd_perm=N, upd_clean=0.
REQ-027 SHALL cover ProbeBlock toB size=6 addr 0x1028, hit T dirty=1 -> 8 ProbeAckData beats, param TtoB(0), rd_addr 0x1000..0x1038 step 8, upd_perm=B, upd_clean=1.
REQ-028 SHALL cover ProbeBlock toT, miss -> ProbeAck NtoN(5), no rd_req_o, upd_perm=N.
REQ-029 SHALL cover c_ready_i low 4 cycles during beat 3 -> c_data_o and all C fields unchanged, no extra rd_req_o.
REQ-030 SHALL cover rst_i asserted during beat 2 of 8 -> outputs 0 immediately, no upd_valid_o, next probe after reset handled normally.

Source files
------------

// File: rtl/tl_probe_responder.sv
// TileLink B-channel probe responder: looks up the line, downgrades it and
// answers on the C channel with ProbeAck or a multi-beat ProbeAckData.
module tl_probe_responder #(
  parameter int AddrWidth   = 56,
  parameter int DataWidth   = 64,
  parameter int SourceWidth = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   b_valid_i,
  input  logic [2:0]             b_opcode_i,
  input  logic [2:0]             b_param_i,
  input  logic [2:0]             b_size_i,
  input  logic [SourceWidth-1:0] b_source_i,
  input  logic [AddrWidth-1:0]   b_address_i,
  output logic                   b_ready_o,
  output logic                   lkp_req_o,
  output logic [AddrWidth-1:0]   lkp_addr_o,
  input  logic                   lkp_hit_i,
  input  logic [1:0]             lkp_perm_i,
  input  logic                   lkp_dirty_i,
  output logic                   rd_req_o,
  output logic [AddrWidth-1:0]   rd_addr_o,
  input  logic [DataWidth-1:0]   rd_data_i,
  output logic                   upd_valid_o,
  output logic [AddrWidth-1:0]   upd_addr_o,
  output logic [1:0]             upd_perm_o,
  output logic                   upd_clean_o,
  output logic                   c_valid_o,
  output logic [2:0]             c_opcode_o,
  output logic [2:0]             c_param_o,
  output logic [2:0]             c_size_o,
  output logic [SourceWidth-1:0] c_source_o,
  output logic [AddrWidth-1:0]   c_address_o,
  output logic [DataWidth-1:0]   c_data_o,
  input  logic                   c_ready_i
);
  localparam int BL       = DataWidth / 8;
  localparam int LgBL     = $clog2(BL);
  localparam int MaxBeats = (BL >= 128) ? 1 : 128 / BL;
  localparam int BeatW    = (MaxBeats > 1) ? $clog2(MaxBeats) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOOKUP  = 3'd1,
    DECIDE  = 3'd2,
    READ    = 3'd3,
    CAPTURE = 3'd4,
    SEND    = 3'd5
  } state_t;

  state_t                 state;
  state_t                 nextState;
  logic [2:0]             opcodeReg;
  logic [2:0]             capReg;
  logic [2:0]             sizeReg;
  logic [SourceWidth-1:0] sourceReg;
  logic [AddrWidth-1:0]   addrReg;
  logic [2:0]             cOpcodeReg;
  logic [2:0]             cParamReg;
  logic [1:0]             updPermReg;
  logic                   updCleanReg;
  logic [BeatW-1:0]       beatReg;
  logic [DataWidth-1:0]   dataReg;

  logic [1:0]             curPerm;
  logic                   curDirty;
  logic [1:0]             capPerm;
  logic [2:0]             paramNext;
  logic [1:0]             permNext;
  logic                   sendData;
  logic [31:0]            sizeBytes;
  logic [31:0]            lastIdx;
  logic                   lastBeat;
  logic [AddrWidth-1:0]   sizeMask;
  logic [AddrWidth-1:0]   rdAddr;
  logic                   sending;

  // Downgrade decision from the lookup result and the latched cap (2=T,1=B,0=N)
  always_comb begin
    curPerm   = 2'd0;
    capPerm   = 2'd0;
    paramNext = 3'd5;
    permNext  = 2'd0;
    if (lkp_hit_i && (lkp_perm_i != 2'd3)) begin
      curPerm = lkp_perm_i;
    end else begin
      curPerm = 2'd0;
    end
    curDirty = lkp_hit_i & lkp_dirty_i;
    case (capReg)
      3'd0:    capPerm = 2'd2;
      3'd1:    capPerm = 2'd1;
      default: capPerm = 2'd0;
    endcase
    case (curPerm)
      2'd2: begin
        case (capPerm)
          2'd2:    begin paramNext = 3'd3; permNext = 2'd2; end
          2'd1:    begin paramNext = 3'd0; permNext = 2'd1; end
          default: begin paramNext = 3'd1; permNext = 2'd0; end
        endcase
      end
      2'd1: begin
        if (capPerm == 2'd0) begin
          paramNext = 3'd2;
          permNext  = 2'd0;
        end else begin
          paramNext = 3'd4;
          permNext  = 2'd1;
        end
      end
      default: begin
        paramNext = 3'd5;
        permNext  = 2'd0;
      end
    endcase
    sendData = (opcodeReg == 3'd6) && (curPerm == 2'd2) && curDirty;
  end

  // Beat bookkeeping and the aligned read address of the current beat
  always_comb begin
    sizeBytes = 32'd1 << sizeReg;
    if (sizeBytes > 32'(BL)) begin
      lastIdx = (sizeBytes >> LgBL) - 32'd1;
    end else begin
      lastIdx = 32'd0;
    end
    // A dataless ProbeAck is always a single beat, whatever the size
    lastBeat = !updCleanReg || ({{(32-BeatW){1'b0}}, beatReg} == lastIdx);
    sizeMask = (AddrWidth'(1) << sizeReg) - AddrWidth'(1);
    rdAddr   = (addrReg & ~sizeMask) + (AddrWidth'(beatReg) << LgBL);
  end

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic
  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (b_valid_i) nextState = LOOKUP;
        else           nextState = IDLE;
      end
      LOOKUP:  nextState = DECIDE;
      DECIDE: begin
        if (sendData) nextState = READ;
        else          nextState = SEND;
      end
      READ:    nextState = CAPTURE;
      CAPTURE: nextState = SEND;
      SEND: begin
        if (!c_ready_i)    nextState = SEND;
        else if (lastBeat) nextState = IDLE;
        else               nextState = READ;
      end
      default: nextState = IDLE;
    endcase
  end

  // Probe fields, response fields, beat counter and captured data
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      opcodeReg   <= 3'd0;
      capReg      <= 3'd0;
      sizeReg     <= 3'd0;
      sourceReg   <= {SourceWidth{1'b0}};
      addrReg     <= {AddrWidth{1'b0}};
      cOpcodeReg  <= 3'd0;
      cParamReg   <= 3'd0;
      updPermReg  <= 2'd0;
      updCleanReg <= 1'b0;
      beatReg     <= {BeatW{1'b0}};
      dataReg     <= {DataWidth{1'b0}};
    end else begin
      case (state)
        IDLE: begin
          if (b_valid_i) begin
            opcodeReg <= b_opcode_i;
            capReg    <= b_param_i;
            sizeReg   <= b_size_i;
            sourceReg <= b_source_i;
            addrReg   <= b_address_i;
          end
        end
        DECIDE: begin
          cOpcodeReg  <= sendData ? 3'd5 : 3'd4;
          cParamReg   <= paramNext;
          updPermReg  <= permNext;
          updCleanReg <= sendData;
          beatReg     <= {BeatW{1'b0}};
          dataReg     <= {DataWidth{1'b0}};
        end
        CAPTURE: dataReg <= rd_data_i;
        SEND: begin
          if (c_ready_i && !lastBeat) beatReg <= beatReg + BeatW'(1);
        end
        default: ;
      endcase
    end
  end

  assign sending     = (state == SEND);
  assign b_ready_o   = (state == IDLE) && !rst_i;
  assign lkp_req_o   = (state == LOOKUP);
  assign lkp_addr_o  = lkp_req_o ? addrReg : {AddrWidth{1'b0}};
  assign rd_req_o    = (state == READ);
  assign rd_addr_o   = rd_req_o ? rdAddr : {AddrWidth{1'b0}};
  assign c_valid_o   = sending;
  assign c_opcode_o  = sending ? cOpcodeReg : 3'd0;
  assign c_param_o   = sending ? cParamReg : 3'd0;
  assign c_size_o    = sending ? sizeReg : 3'd0;
  assign c_source_o  = sending ? sourceReg : {SourceWidth{1'b0}};
  assign c_address_o = sending ? addrReg : {AddrWidth{1'b0}};
  assign c_data_o    = sending ? dataReg : {DataWidth{1'b0}};
  assign upd_valid_o = sending && c_ready_i && lastBeat;
  assign upd_addr_o  = upd_valid_o ? addrReg : {AddrWidth{1'b0}};
  assign upd_perm_o  = upd_valid_o ? updPermReg : 2'd0;
  assign upd_clean_o = upd_valid_o && updCleanReg;

endmodule

// File: tb/tb_tl_probe_responder.sv
// Randomized scoreboard bench for tl_probe_responder: a permission-rank model
// predicts every lookup, read and C beat; a monitor compares as they appear.
module tb_tl_probe_responder;
  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        b_valid_i = 1'b0;
  logic [2:0]  b_opcode_i = 3'd0;
  logic [2:0]  b_param_i = 3'd0;
  logic [2:0]  b_size_i = 3'd0;
  logic [0:0]  b_source_i = 1'b0;
  logic [55:0] b_address_i = 56'd0;
  logic        b_ready_o;
  logic        lkp_req_o;
  logic [55:0] lkp_addr_o;
  logic        lkp_hit_i = 1'b0;
  logic [1:0]  lkp_perm_i = 2'd0;
  logic        lkp_dirty_i = 1'b0;
  logic        rd_req_o;
  logic [55:0] rd_addr_o;
  logic [63:0] rd_data_i = 64'd0;
  logic        upd_valid_o;
  logic [55:0] upd_addr_o;
  logic [1:0]  upd_perm_o;
  logic        upd_clean_o;
  logic        c_valid_o;
  logic [2:0]  c_opcode_o;
  logic [2:0]  c_param_o;
  logic [2:0]  c_size_o;
  logic [0:0]  c_source_o;
  logic [55:0] c_address_o;
  logic [63:0] c_data_o;
  logic        c_ready_i = 1'b1;

  tl_probe_responder dut (
    .clk_i(clk), .rst_i(rst_i),
    .b_valid_i(b_valid_i), .b_opcode_i(b_opcode_i), .b_param_i(b_param_i),
    .b_size_i(b_size_i), .b_source_i(b_source_i), .b_address_i(b_address_i),
    .b_ready_o(b_ready_o),
    .lkp_req_o(lkp_req_o), .lkp_addr_o(lkp_addr_o), .lkp_hit_i(lkp_hit_i),
    .lkp_perm_i(lkp_perm_i), .lkp_dirty_i(lkp_dirty_i),
    .rd_req_o(rd_req_o), .rd_addr_o(rd_addr_o), .rd_data_i(rd_data_i),
    .upd_valid_o(upd_valid_o), .upd_addr_o(upd_addr_o), .upd_perm_o(upd_perm_o),
    .upd_clean_o(upd_clean_o),
    .c_valid_o(c_valid_o), .c_opcode_o(c_opcode_o), .c_param_o(c_param_o),
    .c_size_o(c_size_o), .c_source_o(c_source_o), .c_address_o(c_address_o),
    .c_data_o(c_data_o), .c_ready_i(c_ready_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] ctrl;
    logic [55:0] addr;
    logic [63:0] data;
    bit          first;
    int          firstCycle;
    bit          last;
    logic [1:0]  updPerm;
    bit          updClean;
  } beat_t;

  typedef struct {
    logic [55:0] addr;
    int          cyc;
  } lkp_t;

  beat_t       cq[$];
  logic [55:0] rdq[$];
  lkp_t        lkq[$];
  int cyc = 0;
  int nChecks = 0;
  int nFail = 0;
  int hsInProbe = 0;
  int lastHs = 0;
  bit prevValid = 1'b0;
  bit readyRandom = 1'b0;
  bit stallArm = 1'b0;
  int stallLeft = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] memData(input logic [55:0] a);
    return {a[31:0] ^ 32'h5A5A_1234, ~a[31:0]};
  endfunction

  // Permission ranks N=0,B=1,T=2; the C param names the (old,new) pair
  function automatic logic [2:0] paramOf(input int cur, input int nw);
    if (cur == 2) return (nw == 2) ? 3'd3 : ((nw == 1) ? 3'd0 : 3'd1);
    if (cur == 1) return (nw == 1) ? 3'd4 : 3'd2;
    return 3'd5;
  endfunction

  task automatic issue(input logic [2:0] op, input logic [2:0] cap, input logic [2:0] size,
                       input logic src, input logic [55:0] addr,
                       input bit hit, input logic [1:0] perm, input bit dirty);
    int t, cur, capRank, nw, beats;
    bit isData, seen;
    logic [55:0] base;
    beat_t b;
    @(posedge clk); #1;
    b_valid_i = 1'b1; b_opcode_i = op; b_param_i = cap; b_size_i = size;
    b_source_i = src; b_address_i = addr;
    lkp_hit_i = hit; lkp_perm_i = perm; lkp_dirty_i = dirty;
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      seen = b_ready_o;
    end
    if (!seen) begin
      chk("b_ready_timeout", b_ready_o, 1);
      b_valid_i = 1'b0;
      return;
    end
    t = cyc;
    lkq.push_back('{addr, t + 1});
    cur = hit ? int'(perm) : 0;
    capRank = (cap == 3'd0) ? 2 : ((cap == 3'd1) ? 1 : 0);
    nw = (cur < capRank) ? cur : capRank;
    isData = (op == 3'd6) && (cur == 2) && hit && dirty;
    beats = ((1 << size) <= 8) ? 1 : (1 << size) / 8;
    base = addr & ~((56'd1 << size) - 56'd1);
    if (!isData) beats = 1;
    for (int i = 0; i < beats; i++) begin
      b.ctrl = {(isData ? 3'd5 : 3'd4), paramOf(cur, nw), size, 3'(src)};
      b.addr = addr;
      b.data = isData ? memData(base + 56'(8 * i)) : 64'd0;
      b.first = (i == 0);
      b.firstCycle = t + (isData ? 5 : 3);
      b.last = (i == beats - 1);
      b.updPerm = 2'(nw);
      b.updClean = isData;
      cq.push_back(b);
      if (isData) rdq.push_back(base + 56'(8 * i));
    end
    @(posedge clk); #1;
    b_valid_i = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 800 && cq.size() != 0; i++) @(negedge clk);
    chk("drain_pending_beats", cq.size(), 0);
  endtask

  // Read-port memory: data for the requested address the cycle after rd_req
  initial forever begin
    @(negedge clk);
    if (rd_req_o) rd_data_i = memData(rd_addr_o);
  end

  // C-channel ready driver with an optional 4-cycle stall on the third beat
  initial forever begin
    @(posedge clk); #1;
    if (stallLeft > 0) begin
      c_ready_i = 1'b0;
      stallLeft--;
    end else if (stallArm && c_valid_o && hsInProbe == 2) begin
      stallArm = 1'b0;
      stallLeft = 3;
      c_ready_i = 1'b0;
    end else begin
      c_ready_i = readyRandom ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // Monitor: pops expected lookups, reads and C beats as the DUT presents them
  initial forever begin
    beat_t h;
    lkp_t l;
    @(negedge clk);
    if (rst_i) begin
      prevValid = 1'b0;
    end else begin
      if (lkp_req_o) begin
        if (lkq.size() == 0) chk("lkp_extra_req", lkp_req_o, 0);
        else begin
          l = lkq.pop_front();
          chk("lkp_addr", lkp_addr_o, l.addr);
          chk("lkp_cycle", cyc, l.cyc);
        end
      end
      if (rd_req_o) begin
        chk("rd_while_c_valid", c_valid_o, 0);
        if (rdq.size() == 0) chk("rd_extra_req", rd_req_o, 0);
        else chk("rd_addr", rd_addr_o, rdq.pop_front());
      end
      if (upd_valid_o) begin
        chk("upd_with_handshake", c_valid_o & c_ready_i, 1);
        chk("b_ready_in_final_hs", b_ready_o, 0);
      end
      if (c_valid_o) begin
        chk("b_ready_while_send", b_ready_o, 0);
        if (cq.size() == 0) chk("c_valid_unexpected", c_valid_o, 0);
        else begin
          h = cq[0];
          if (!prevValid) begin
            if (h.first) chk("latency_first_beat", cyc, h.firstCycle);
            else         chk("latency_next_beat", cyc, lastHs + 3);
          end
          chk("c_ctrl", {c_opcode_o, c_param_o, c_size_o, 3'(c_source_o)}, h.ctrl);
          chk("c_address", c_address_o, h.addr);
          chk("c_data", c_data_o, h.data);
          if (c_ready_i) begin
            chk("upd_valid", upd_valid_o, h.last);
            if (h.last) begin
              chk("upd_addr", upd_addr_o, h.addr);
              chk("upd_perm", upd_perm_o, h.updPerm);
              chk("upd_clean", upd_clean_o, h.updClean);
            end
            void'(cq.pop_front());
            lastHs = cyc;
            hsInProbe = h.last ? 0 : hsInProbe + 1;
          end
        end
      end
      prevValid = c_valid_o & ~c_ready_i;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0] op;
    repeat (3) @(negedge clk);
    chk("reset_b_ready", b_ready_o, 0);
    chk("reset_c_valid", c_valid_o, 0);
    chk("reset_outputs", {lkp_req_o, rd_req_o, upd_valid_o, c_data_o, c_address_o}, 0);
    @(posedge clk); #1 rst_i = 1'b0;
    @(negedge clk);
    chk("b_ready_after_reset", b_ready_o, 1);

    // ProbePerm toN on a dirty T line: single ProbeAck TtoN
    issue(3'd7, 3'd2, 3'd3, 1'b0, 56'h2040, 1'b1, 2'd2, 1'b1);
    // ProbeBlock toB on a dirty T line: eight data beats from 0x1000
    issue(3'd6, 3'd1, 3'd6, 1'b1, 56'h1028, 1'b1, 2'd2, 1'b1);
    // ProbeBlock toT that misses: NtoN with no reads
    issue(3'd6, 3'd0, 3'd6, 1'b0, 56'h3000, 1'b0, 2'd2, 1'b1);
    drain();

    stallArm = 1'b1;
    issue(3'd6, 3'd0, 3'd6, 1'b0, 56'h4480, 1'b1, 2'd2, 1'b1);
    drain();
    chk("stall_applied", stallArm, 0);

    // Reset during the second of eight data beats
    issue(3'd6, 3'd2, 3'd6, 1'b1, 56'h5010, 1'b1, 2'd2, 1'b1);
    for (int i = 0; i < 200; i++) begin
      if (c_valid_o && c_data_o == memData(56'h5008)) break;
      @(negedge clk);
    end
    chk("rst_beat2_present", c_valid_o, 1);
    #1 rst_i = 1'b1;
    #1;
    chk("rst_c_valid_zero", c_valid_o, 0);
    chk("rst_outputs_zero", {b_ready_o, lkp_req_o, rd_req_o, upd_valid_o, c_opcode_o,
                             c_param_o, c_data_o, c_address_o}, 0);
    cq.delete(); rdq.delete(); lkq.delete();
    hsInProbe = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_no_upd", upd_valid_o, 0);
      chk("rst_no_c_valid", c_valid_o, 0);
    end
    @(posedge clk); #1 rst_i = 1'b0;
    @(negedge clk);
    chk("b_ready_after_midreset", b_ready_o, 1);
    issue(3'd6, 3'd1, 3'd5, 1'b0, 56'h6020, 1'b1, 2'd2, 1'b1);
    drain();

    readyRandom = 1'b1;
    for (int n = 0; n < 120; n++) begin
      int r;
      r = $urandom_range(0, 9);
      op = (r < 4) ? 3'd6 : ((r < 8) ? 3'd7 : 3'($urandom_range(0, 7)));
      issue(op, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            {24'($urandom), 32'($urandom)}, 1'($urandom_range(0, 1)),
            2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end
    drain();
    chk("rd_queue_empty", rdq.size(), 0);
    chk("lkp_queue_empty", lkq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end
endmodule
